sat_engine_seq: RTL and testbench
=================================

Name: sat_engine_seq

Overview:
- Parametrised next-generation sequencer for the bin SAT engine.
- Drives the imply / decide / analyze / backtrack handshakes towards state_list and clause_array.
- Adds features the current core controller lacks: runtime conflict and cycle budgets, external abort, an encoded completion status, and saturating statistics counters.
- Sits inside the engine top, between the bin-level controller (start/done) and the engine datapath.

Parameters:
WIDTH_LVL, 16, width of level / bin-number fields
WIDTH_BIN_ID, 10, width of backtrack bin id
WIDTH_CNT, 16, width of budget inputs and statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_core_i  in  1  start solving current bin (pulse, honoured in IDLE only)
abort_i  in  1  external abort request (pulse or level)
conflict_budget_i  in  WIDTH_CNT  max conflicts, 0 = unlimited; latched at start
cycle_budget_i  in  WIDTH_CNT  max busy cycles, 0 = unlimited; latched at start
cur_bin_num_i  in  WIDTH_LVL  bin being solved
apply_imply_o  out  1  imply request (level)
done_imply_i  in  1  imply complete
conflict_i  in  1  conflict found; valid with done_imply_i
all_c_is_sat_i  in  1  all clauses satisfied; valid with done_imply_i
start_decision_o  out  1  decision request (level)
done_decision_i  in  1  decision complete
apply_analyze_o  out  1  conflict-analysis request (level)
done_analyze_i  in  1  analysis complete
bkt_bin_num_i  in  WIDTH_BIN_ID  backtrack target bin; valid with done_analyze_i
apply_bkt_cur_bin_o  out  1  in-bin backtrack request (level)
done_bkt_cur_bin_i  in  1  backtrack complete
done_core_o  out  1  one-cycle completion pulse
busy_o  out  1  high in any state except IDLE
status_o  out  2  0 none, 1 SAT, 2 UNSAT (backtrack leaves bin), 3 ABORT
abort_cause_o  out  2  0 external, 1 conflict budget, 2 cycle budget; valid when status_o = 3
sat_o  out  1  equals (status_o == 1)
unsat_o  out  1  equals (status_o == 2)
conflict_cnt_o  out  WIDTH_CNT  conflicts in current run
decision_cnt_o  out  WIDTH_CNT  decisions in current run
cycle_cnt_o  out  WIDTH_CNT  busy cycles in current run

Behaviour:

Reset values:
- State IDLE.
- All request outputs, done_core_o and busy_o = 0.
- status_o = 0, abort_cause_o = 0.
- Counters = 0, abort_pending = 0.
- Reset mid-operation aborts immediately with no done pulse.

States: IDLE, IMPLY, DECIDE, ANALYZE, BKT, DONE.

Requests:
- apply_imply_o, start_decision_o, apply_analyze_o and apply_bkt_cur_bin_o are each high exactly while in their own state.
- The request drops in the cycle after the corresponding done_* is sampled high.
- A done_* input arriving outside its matching state is ignored.

IDLE:
- On start_core_i: latch both budgets, clear counters, status_o and abort_pending, then go to IMPLY.
- start_core_i in any other state is ignored.

IMPLY, on done_imply_i, in priority order:
1. conflict_i: conflict_cnt++. If budget is nonzero and new count == budget, go to DONE with ABORT, cause 1. Otherwise go to ANALYZE.
2. all_c_is_sat_i: go to DONE with SAT.
3. abort_pending: go to DONE with ABORT and the latched cause.
4. Otherwise go to DECIDE.

DECIDE, on done_decision_i:
- decision_cnt++.
- If abort_pending, go to DONE with ABORT; otherwise go to IMPLY.

ANALYZE, on done_analyze_i:
- If bkt_bin_num_i != cur_bin_num_i (zero-extended to the wider width), go to DONE with UNSAT.
- Else if abort_pending, go to DONE with ABORT.
- Else go to BKT.

BKT, on done_done_bkt_cur_bin_i:
- If abort_pending, go to DONE with ABORT; otherwise go to IMPLY.

DONE:
- done_core_o = 1 for exactly one cycle, then IDLE.
- status_o and abort_cause_o hold until the next accepted start.

Abort pending:
- Set by abort_i (cause 0), or when cycle_cnt reaches a nonzero cycle budget (cause 2), in any busy state except DONE.
- The first cause to be set wins.
- The pending abort is taken only at a handshake boundary, so no datapath operation is ever cut off.
- A SAT or UNSAT outcome on the same boundary beats a pending abort.

Counters:
- cycle_cnt increments every cycle in a busy state other than DONE.
- All counters saturate at all-ones and never wrap.
- A budget equal to all-ones is therefore reachable.

Test Plan:
- Reset, then start; imply returns done with all_c_is_sat=1 after 3 cycles -> done_core_o pulses once, status_o=1, sat_o=1, cycle_cnt_o=4, decision_cnt_o=0.
- Three rounds of imply(no conflict) then decide, then imply with sat=1 -> decision_cnt_o=3, status_o=1; each request high only in its own state.
- cur_bin=5; imply with conflict_i=1, then done_analyze_i with bkt_bin_num_i=2 -> status_o=2, unsat_o=1, conflict_cnt_o=1, apply_bkt_cur_bin_o never asserted.
- conflict_budget_i=2; conflicts on two imply rounds (bkt_bin equal to cur_bin) -> second conflict goes to DONE, status_o=3, abort_cause_o=1, conflict_cnt_o=2, apply_analyze_o asserted only once.
- cycle_budget_i=10 with done_decision_i held off until cycle 15 -> no done before the decision handshake; then status_o=3, abort_cause_o=2; abort_i also pulsed at cycle 12 -> cause stays 2.
- abort_i on the same cycle done_imply_i arrives with all_c_is_sat_i=1 -> status_o=1; rst asserted during ANALYZE -> all outputs return to reset values next cycle and no done_core_o pulse occurs.

Source files
------------

// File: rtl/sat_engine_seq_if.sv
// sat_engine_seq_if: imply/decide/analyze/backtrack handshakes between sequencer and datapath
interface sat_engine_seq_if #(parameter int WIDTH_BIN_ID = 10);
  logic apply_imply_o, done_imply_i, conflict_i, all_c_is_sat_i;
  logic start_decision_o, done_decision_i;
  logic apply_analyze_o, done_analyze_i;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i;
  logic apply_bkt_cur_bin_o, done_bkt_cur_bin_i;
  modport master (
    output apply_imply_o, start_decision_o, apply_analyze_o, apply_bkt_cur_bin_o,
    input done_imply_i, conflict_i, all_c_is_sat_i, done_decision_i, done_analyze_i,
    input bkt_bin_num_i, done_bkt_cur_bin_i
  );
  modport slave (
    input apply_imply_o, start_decision_o, apply_analyze_o, apply_bkt_cur_bin_o,
    output done_imply_i, conflict_i, all_c_is_sat_i, done_decision_i, done_analyze_i,
    output bkt_bin_num_i, done_bkt_cur_bin_i
  );
endinterface

// File: rtl/sat_engine_seq.sv
// sat_engine_seq: bin SAT sequencer with conflict/cycle budgets, abort, status and saturating stats
module sat_engine_seq #(
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_core_i,
  input  logic                 abort_i,
  input  logic [WIDTH_CNT-1:0] conflict_budget_i,
  input  logic [WIDTH_CNT-1:0] cycle_budget_i,
  input  logic [WIDTH_LVL-1:0] cur_bin_num_i,
  sat_engine_seq_if.master     dp,
  output logic                 done_core_o,
  output logic                 busy_o,
  output logic [1:0]           status_o,
  output logic [1:0]           abort_cause_o,
  output logic                 sat_o,
  output logic                 unsat_o,
  output logic [WIDTH_CNT-1:0] conflict_cnt_o,
  output logic [WIDTH_CNT-1:0] decision_cnt_o,
  output logic [WIDTH_CNT-1:0] cycle_cnt_o
);
  localparam int WCMP = WIDTH_LVL > WIDTH_BIN_ID ? WIDTH_LVL : WIDTH_BIN_ID;
  typedef enum logic [2:0] {IDLE, IMPLY, DECIDE, ANALYZE, BKT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH_CNT-1:0] conf_budget, cyc_budget, conf_cnt, dec_cnt, cyc_cnt;
  logic [WIDTH_CNT-1:0] conf_inc, dec_inc, cyc_inc;
  logic [1:0] status, cause, fin_st, fin_cause, pend_cause;
  logic pend, fin, working, cyc_hit, bkt_leaves;
  assign conf_inc = &conf_cnt ? conf_cnt : conf_cnt + WIDTH_CNT'(1);
  assign dec_inc = &dec_cnt ? dec_cnt : dec_cnt + WIDTH_CNT'(1);
  assign cyc_inc = &cyc_cnt ? cyc_cnt : cyc_cnt + WIDTH_CNT'(1);
  assign working = state inside {IMPLY, DECIDE, ANALYZE, BKT};
  assign cyc_hit = cyc_budget != '0 && cyc_inc == cyc_budget;
  assign bkt_leaves = WCMP'(dp.bkt_bin_num_i) != WCMP'(cur_bin_num_i);
  // fin selects DONE; fin_st/fin_cause carry the outcome recorded on that transition
  always_comb begin
    state_nxt = state;
    fin = 1'b0;
    fin_st = 2'd3;
    fin_cause = pend_cause;
    case (state)
      IDLE: state_nxt = start_core_i ? IMPLY : IDLE;
      IMPLY:
        if (dp.done_imply_i) begin
          if (dp.conflict_i) begin
            fin = conf_budget != '0 && conf_inc == conf_budget;
            fin_cause = 2'd1;
            state_nxt = ANALYZE;
          end else if (dp.all_c_is_sat_i) begin
            fin = 1'b1;
            fin_st = 2'd1;
          end else if (pend) fin = 1'b1;
          else state_nxt = DECIDE;
        end
      DECIDE:
        if (dp.done_decision_i) begin
          fin = pend;
          state_nxt = IMPLY;
        end
      ANALYZE:
        if (dp.done_analyze_i) begin
          fin = bkt_leaves | pend;
          fin_st = bkt_leaves ? 2'd2 : 2'd3;
          state_nxt = BKT;
        end
      BKT:
        if (dp.done_bkt_cur_bin_i) begin
          fin = pend;
          state_nxt = IMPLY;
        end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (fin) state_nxt = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      status <= '0;
      cause <= '0;
      conf_cnt <= '0;
      dec_cnt <= '0;
      cyc_cnt <= '0;
      pend <= 1'b0;
      pend_cause <= '0;
      conf_budget <= '0;
      cyc_budget <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_core_i) begin
        conf_budget <= conflict_budget_i;
        cyc_budget <= cycle_budget_i;
        conf_cnt <= '0;
        dec_cnt <= '0;
        cyc_cnt <= '0;
        status <= '0;
        cause <= '0;
        pend <= 1'b0;
      end
      if (fin) begin
        status <= fin_st;
        cause <= fin_st == 2'd3 ? fin_cause : 2'd0;
      end
      if (working) cyc_cnt <= cyc_inc;
      if (state == IMPLY && dp.done_imply_i && dp.conflict_i) conf_cnt <= conf_inc;
      if (state == DECIDE && dp.done_decision_i) dec_cnt <= dec_inc;
      if (working && !pend && (abort_i || cyc_hit)) begin
        pend <= 1'b1;
        pend_cause <= abort_i ? 2'd0 : 2'd2;
      end
    end
  end
  assign dp.apply_imply_o = state == IMPLY;
  assign dp.start_decision_o = state == DECIDE;
  assign dp.apply_analyze_o = state == ANALYZE;
  assign dp.apply_bkt_cur_bin_o = state == BKT;
  assign done_core_o = state == DONE;
  assign busy_o = state != IDLE;
  assign status_o = status;
  assign abort_cause_o = cause;
  assign sat_o = status == 2'd1;
  assign unsat_o = status == 2'd2;
  assign conflict_cnt_o = conf_cnt;
  assign decision_cnt_o = dec_cnt;
  assign cycle_cnt_o = cyc_cnt;
endmodule

// File: tb/tb_sat_engine_seq.sv
// tb_sat_engine_seq: directed scenarios checked each cycle against a behavioural reference model
module tb_sat_engine_seq;
  logic clk = 0, rst = 1, start_core_i = 0, abort_i = 0;
  logic [15:0] conflict_budget_i = 0, cycle_budget_i = 0, cur_bin_num_i = 0;
  logic done_core_o, busy_o, sat_o, unsat_o;
  logic [1:0] status_o, abort_cause_o;
  logic [15:0] conflict_cnt_o, decision_cnt_o, cycle_cnt_o;
  int tests = 0, fails = 0, tick = 0, s0 = 0, done_cnt = 0, an_rises = 0, bkt_rises = 0;
  bit armed = 0, prev_an = 0, prev_bkt = 0, mw = 0;
  int m_ph = 0;
  logic [1:0] m_st, m_ca, m_pc;
  logic [15:0] m_conf, m_dec, m_cyc, m_cb, m_yb;
  bit m_pend;

  sat_engine_seq_if #(.WIDTH_BIN_ID(10)) dp ();

  sat_engine_seq #(.WIDTH_LVL(16), .WIDTH_BIN_ID(10), .WIDTH_CNT(16)) dut (
    .clk(clk), .rst(rst), .start_core_i(start_core_i), .abort_i(abort_i),
    .conflict_budget_i(conflict_budget_i), .cycle_budget_i(cycle_budget_i),
    .cur_bin_num_i(cur_bin_num_i), .dp(dp), .done_core_o(done_core_o), .busy_o(busy_o),
    .status_o(status_o), .abort_cause_o(abort_cause_o), .sat_o(sat_o), .unsat_o(unsat_o),
    .conflict_cnt_o(conflict_cnt_o), .decision_cnt_o(decision_cnt_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] x);
    return x == 16'hffff ? x : x + 16'd1;
  endfunction

  task automatic fin_m(input logic [1:0] st, input logic [1:0] ca);
    m_st = st;
    m_ca = ca;
    m_ph = 5;
  endtask

  // reference model; phases 0 idle, 1 imply, 2 decide, 3 analyze, 4 backtrack, 5 done
  always @(posedge clk) begin
    armed = 1;
    tick++;
    if (rst) begin
      m_ph = 0; m_st = 0; m_ca = 0; m_conf = 0; m_dec = 0; m_cyc = 0;
      m_pend = 0; m_pc = 0; m_cb = 0; m_yb = 0;
    end else begin
      mw = m_ph >= 1 && m_ph <= 4;
      case (m_ph)
        0: if (start_core_i) begin
          m_cb = conflict_budget_i; m_yb = cycle_budget_i;
          m_conf = 0; m_dec = 0; m_cyc = 0; m_st = 0; m_ca = 0; m_pend = 0; m_ph = 1;
        end
        1: if (dp.done_imply_i) begin
          if (dp.conflict_i) begin
            m_conf = sat16(m_conf);
            if (m_cb != 0 && m_conf == m_cb) fin_m(3, 1); else m_ph = 3;
          end else if (dp.all_c_is_sat_i) fin_m(1, 0);
          else if (m_pend) fin_m(3, m_pc);
          else m_ph = 2;
        end
        2: if (dp.done_decision_i) begin
          m_dec = sat16(m_dec);
          if (m_pend) fin_m(3, m_pc); else m_ph = 1;
        end
        3: if (dp.done_analyze_i) begin
          if ({6'b0, dp.bkt_bin_num_i} != cur_bin_num_i) fin_m(2, 0);
          else if (m_pend) fin_m(3, m_pc);
          else m_ph = 4;
        end
        4: if (dp.done_bkt_cur_bin_i) begin
          if (m_pend) fin_m(3, m_pc); else m_ph = 1;
        end
        default: m_ph = 0;
      endcase
      if (mw) begin
        m_cyc = sat16(m_cyc);
        if (!m_pend && (abort_i || (m_yb != 0 && m_cyc == m_yb))) begin
          m_pend = 1;
          m_pc = abort_i ? 2'd0 : 2'd2;
        end
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("apply_imply", dp.apply_imply_o, m_ph == 1);
    chk("start_decision", dp.start_decision_o, m_ph == 2);
    chk("apply_analyze", dp.apply_analyze_o, m_ph == 3);
    chk("apply_bkt", dp.apply_bkt_cur_bin_o, m_ph == 4);
    chk("done_core", done_core_o, m_ph == 5);
    chk("busy", busy_o, m_ph != 0);
    chk("status", status_o, m_st);
    chk("abort_cause", abort_cause_o, m_ca);
    chk("sat", sat_o, m_st == 1);
    chk("unsat", unsat_o, m_st == 2);
    chk("conflict_cnt", conflict_cnt_o, m_conf);
    chk("decision_cnt", decision_cnt_o, m_dec);
    chk("cycle_cnt", cycle_cnt_o, m_cyc);
    if (done_core_o) done_cnt++;
    if (dp.apply_analyze_o && !prev_an) an_rises++;
    if (dp.apply_bkt_cur_bin_o && !prev_bkt) bkt_rises++;
    prev_an = dp.apply_analyze_o;
    prev_bkt = dp.apply_bkt_cur_bin_o;
  end

  function automatic logic req(input int w);
    case (w)
      1: return dp.apply_imply_o;
      2: return dp.start_decision_o;
      3: return dp.apply_analyze_o;
      default: return dp.apply_bkt_cur_bin_o;
    endcase
  endfunction

  task automatic wait_req(input int w);
    int i = 0;
    while (!req(w) && i < 100) begin @(negedge clk); i++; end
    chk($sformatf("req%0d_seen", w), req(w), 1);
  endtask

  task automatic start_run(input logic [15:0] cb, input logic [15:0] yb, input logic [15:0] bin);
    conflict_budget_i = cb; cycle_budget_i = yb; cur_bin_num_i = bin;
    start_core_i = 1;
    @(negedge clk);
    start_core_i = 0;
    s0 = tick;
    an_rises = 0; bkt_rises = 0;
  endtask

  task automatic at(input int k);
    while (tick < s0 + k - 1) @(negedge clk);
  endtask

  task automatic imply_resp(input int d, input bit c, input bit sa);
    wait_req(1);
    repeat (d) @(negedge clk);
    dp.done_imply_i = 1; dp.conflict_i = c; dp.all_c_is_sat_i = sa;
    @(negedge clk);
    dp.done_imply_i = 0; dp.conflict_i = 0; dp.all_c_is_sat_i = 0;
  endtask

  task automatic decide_resp(input int d);
    wait_req(2);
    repeat (d) @(negedge clk);
    dp.done_decision_i = 1;
    @(negedge clk);
    dp.done_decision_i = 0;
  endtask

  task automatic analyze_resp(input int d, input logic [9:0] b);
    wait_req(3);
    repeat (d) @(negedge clk);
    dp.done_analyze_i = 1; dp.bkt_bin_num_i = b;
    @(negedge clk);
    dp.done_analyze_i = 0;
  endtask

  task automatic bkt_resp(input int d);
    wait_req(4);
    repeat (d) @(negedge clk);
    dp.done_bkt_cur_bin_i = 1;
    @(negedge clk);
    dp.done_bkt_cur_bin_i = 0;
  endtask

  task automatic wait_done();
    int i = 0;
    while (!done_core_o && i < 200) begin @(negedge clk); i++; end
    chk("done_seen", done_core_o, 1);
  endtask

  initial begin
    int d0;
    dp.done_imply_i = 0; dp.conflict_i = 0; dp.all_c_is_sat_i = 0; dp.done_decision_i = 0;
    dp.done_analyze_i = 0; dp.bkt_bin_num_i = 0; dp.done_bkt_cur_bin_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_status", status_o, 0);
    rst = 0;
    @(negedge clk);
    // immediate SAT after four imply cycles
    start_run(0, 0, 0);
    imply_resp(3, 0, 1);
    wait_done();
    chk("s1_status", status_o, 1);
    chk("s1_sat", sat_o, 1);
    chk("s1_cycles", cycle_cnt_o, 4);
    chk("s1_decisions", decision_cnt_o, 0);
    @(negedge clk);
    chk("s1_idle", busy_o, 0);
    // three decide rounds with stray done and start pulses that must be ignored
    start_run(0, 0, 0);
    wait_req(1);
    dp.done_decision_i = 1; start_core_i = 1;
    @(negedge clk);
    dp.done_decision_i = 0; start_core_i = 0;
    for (int r = 0; r < 3; r++) begin
      imply_resp(1, 0, 0);
      decide_resp(2);
    end
    imply_resp(0, 0, 1);
    wait_done();
    chk("s2_decisions", decision_cnt_o, 3);
    chk("s2_status", status_o, 1);
    // backtrack target outside the bin gives UNSAT
    @(negedge clk);
    start_run(0, 0, 5);
    imply_resp(1, 1, 0);
    analyze_resp(1, 2);
    wait_done();
    chk("s3_status", status_o, 2);
    chk("s3_unsat", unsat_o, 1);
    chk("s3_conflicts", conflict_cnt_o, 1);
    chk("s3_bkt_rises", bkt_rises, 0);
    // conflict budget of two
    @(negedge clk);
    start_run(2, 0, 7);
    imply_resp(0, 1, 0);
    analyze_resp(0, 7);
    bkt_resp(1);
    imply_resp(0, 1, 0);
    wait_done();
    chk("s4_status", status_o, 3);
    chk("s4_cause", abort_cause_o, 1);
    chk("s4_conflicts", conflict_cnt_o, 2);
    chk("s4_an_rises", an_rises, 1);
    // cycle budget 10 reached while the decision is outstanding; later abort_i does not override
    @(negedge clk);
    start_run(0, 10, 0);
    wait_req(1);
    at(2);
    dp.done_imply_i = 1;
    @(negedge clk);
    dp.done_imply_i = 0;
    at(12);
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    at(15);
    chk("s5_no_early_done", busy_o, 1);
    dp.done_decision_i = 1;
    @(negedge clk);
    dp.done_decision_i = 0;
    wait_done();
    chk("s5_status", status_o, 3);
    chk("s5_cause", abort_cause_o, 2);
    chk("s5_decisions", decision_cnt_o, 1);
    chk("s5_cycles", cycle_cnt_o, 15);
    // SAT beats an abort arriving on the same boundary
    @(negedge clk);
    start_run(0, 0, 0);
    wait_req(1);
    dp.done_imply_i = 1; dp.all_c_is_sat_i = 1; abort_i = 1;
    @(negedge clk);
    dp.done_imply_i = 0; dp.all_c_is_sat_i = 0; abort_i = 0;
    wait_done();
    chk("s6_status", status_o, 1);
    // reset during ANALYZE
    @(negedge clk);
    start_run(0, 0, 3);
    imply_resp(0, 1, 0);
    wait_req(3);
    d0 = done_cnt;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("s7_busy", busy_o, 0);
    chk("s7_analyze", dp.apply_analyze_o, 0);
    chk("s7_status", status_o, 0);
    chk("s7_conflicts", conflict_cnt_o, 0);
    chk("s7_cycles", cycle_cnt_o, 0);
    repeat (4) @(negedge clk);
    chk("s7_no_done", done_cnt, d0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
